// File: rtl/tick_sched.sv
// Clock-enable scheduler: issues a one-cycle tick every div+1 cycles while running,
// with halt-at-boundary, single-step and a HALT-only divide-value handshake.
module tick_sched #(
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned DEFAULT_DIV = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_halt,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             tick,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_count
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_STEP = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic [CNT_W-1:0] r_tick_count;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_tick_nxt;
    logic [CNT_W-1:0] w_tick_count_nxt;
    logic             w_at_period;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_HALT;
            r_cnt        <= '0;
            r_div        <= DIV_W'(DEFAULT_DIV);
            r_tick       <= 1'b0;
            r_tick_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_div        <= w_div_nxt;
            r_tick       <= w_tick_nxt;
            r_tick_count <= w_tick_count_nxt;
        end
    end

    // Next-state, period counter and tick generation
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_tick_nxt  = 1'b0;
        w_at_period = (r_cnt == r_div);

        // RUN and STOP share the same period counting
        if (r_state == S_RUN || r_state == S_STOP) begin
            if (w_at_period) begin
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + DIV_W'(1);
            end
        end

        case (r_state)
            S_HALT: begin
                w_cnt_nxt = '0;
                if (cfg_valid) begin
                    w_div_nxt = cfg_div;
                end
                if (cmd_step) begin
                    w_state_nxt = S_STEP;
                end else if (cmd_run) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cmd_halt) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (cmd_run) begin
                    w_state_nxt = S_RUN;
                end else if (w_at_period) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_STEP: begin
                w_tick_nxt  = 1'b1;
                w_state_nxt = S_HALT;
            end
            default: w_state_nxt = S_HALT;
        endcase

        w_tick_count_nxt = w_tick_nxt ? r_tick_count + CNT_W'(1) : r_tick_count;
    end

    assign cfg_ready  = (r_state == S_HALT);
    assign tick       = r_tick;
    assign state      = 2'(r_state);
    assign tick_count = r_tick_count;

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched: tick timing, cfg handshake, halt/stop/step and
// async reset, plus a CNT_W=4 instance sharing stimulus to observe count wrap.
module tb_tick_sched;

    logic        clk;
    logic        rst_n;
    logic        cmd_run;
    logic        cmd_step;
    logic        cmd_halt;
    logic        cfg_valid;
    logic [31:0] cfg_div;
    logic        cfg_ready;
    logic        tick;
    logic [1:0]  state;
    logic [15:0] tick_count;
    logic        cfg_ready4;
    logic        tick4;
    logic [1:0]  state4;
    logic [3:0]  tick_count4;

    int n_vec;
    int n_err;

    tick_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_halt   (cmd_halt),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .tick       (tick),
        .state      (state),
        .tick_count (tick_count)
    );

    tick_sched #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_halt   (cmd_halt),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready4),
        .tick       (tick4),
        .state      (state4),
        .tick_count (tick_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_run   = 1'b0;
        cmd_step  = 1'b0;
        cmd_halt  = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Enter at RUN cycle 1; leaves at RUN cycle ncyc+1
    task automatic expect_ticks(input string tag, input int div, input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            chk(tag, 32'(tick),
                32'((k >= div + 2) && (((k - div - 2) % (div + 1)) == 0)));
            @(negedge clk);
        end
    endtask

    // From HALT: offer divide value together with run; leaves at RUN cycle 1
    task automatic cfg_and_run(input logic [31:0] div);
        cfg_valid = 1'b1;
        cfg_div   = div;
        cmd_run   = 1'b1;
        chk("cfg_ready_halt", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        cmd_run   = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset values
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_count", 32'(tick_count), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // Default div=15: ticks in RUN cycles 17, 33, 49
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        chk("run_state", 32'(state), 32'd1);
        expect_ticks("def_tick", 15, 49);
        chk("def_count", 32'(tick_count), 32'd3);

        // cfg accepted with run in HALT; refused while running
        do_reset();
        cfg_and_run(32'd2);
        chk("cfg_ready_run", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b1;
        cfg_div   = 32'd7;
        expect_ticks("div2_tick", 2, 12);
        chk("div2_tick13", 32'(tick), 32'd1);
        chk("div2_count", 32'(tick_count), 32'd4);
        chk("div2_cfg_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;

        // div=4, halt at cnt=1: STOP 3 cycles, final tick, then HALT
        do_reset();
        cfg_and_run(32'd4);
        @(negedge clk);
        cmd_halt = 1'b1;
        chk("halt_pre_state", 32'(state), 32'd1);
        @(negedge clk);
        cmd_halt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stop_state", 32'(state), 32'd2);
            chk("stop_tick", 32'(tick), 32'd0);
            @(negedge clk);
        end
        chk("stop_final_tick", 32'(tick), 32'd1);
        chk("stop_final_state", 32'(state), 32'd0);
        chk("stop_final_count", 32'(tick_count), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halted_tick", 32'(tick), 32'd0);
            chk("halted_state", 32'(state), 32'd0);
        end

        // Run again, halt, then cancel with run during STOP: period unbroken
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        @(negedge clk);
        cmd_halt = 1'b1;
        @(negedge clk);
        cmd_halt = 1'b0;
        chk("stop2_state", 32'(state), 32'd2);
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        chk("resume_state", 32'(state), 32'd1);
        for (int k = 4; k <= 11; k++) begin
            chk("resume_tick", 32'(tick), 32'((k == 6) || (k == 11)));
            chk("resume_run", 32'(state), 32'd1);
            if (k != 11) @(negedge clk);
        end
        chk("resume_count", 32'(tick_count), 32'd3);

        // Step wins over run; run during STEP ignored
        do_reset();
        cmd_step = 1'b1;
        cmd_run  = 1'b1;
        @(negedge clk);
        cmd_step = 1'b0;
        chk("step_state", 32'(state), 32'd3);
        chk("step_tick0", 32'(tick), 32'd0);
        @(negedge clk);
        cmd_run = 1'b0;
        chk("step_tick", 32'(tick), 32'd1);
        chk("step_back_halt", 32'(state), 32'd0);
        @(negedge clk);
        chk("step_tick_off", 32'(tick), 32'd0);
        chk("step_halt_stays", 32'(state), 32'd0);
        chk("step_count", 32'(tick_count), 32'd1);

        // div=0: tick every cycle from RUN cycle 2; CNT_W=4 copy wraps
        do_reset();
        cfg_and_run(32'd0);
        expect_ticks("div0_tick", 0, 16);
        chk("wrap4_zero", 32'(tick_count4), 32'd0);
        chk("div0_count16", 32'(tick_count), 32'd16);
        @(negedge clk);
        chk("div0_tick18", 32'(tick), 32'd1);
        chk("div0_count17", 32'(tick_count), 32'd17);
        chk("wrap4_one", 32'(tick_count4), 32'd1);

        // Async reset between edges while tick is high
        #2;
        chk("pre_rst_tick", 32'(tick), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_count", 32'(tick_count), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cmd_run = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        expect_ticks("arst_div15", 15, 18);
        chk("arst_count_after", 32'(tick_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Programmable clock-enable scheduler that sequences the lab CPU datapath.
- Replaces free-running divided clocks with a single-clock-domain one-cycle `tick` enable whose period is configurable.
- Supports run, halt and single-step control for debug.
- Sits between board control inputs (debounced buttons/switches) and every datapath register that advances per CPU step.

Parameters:
- DIV_W, 32, width of divide value and internal period counter.
- DEFAULT_DIV, 15, divide value loaded at reset; tick period = div+1 cycles.
- CNT_W, 16, width of issued-tick counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_run  in  1  level/pulse request to start free-running ticks.
- cmd_step  in  1  request for exactly one tick while halted.
- cmd_halt  in  1  request to stop at the next tick boundary.
- cfg_valid  in  1  new divide value offered.
- cfg_div  in  DIV_W  divide value; period = cfg_div+1 cycles.
- cfg_ready  out  1  config accepted this cycle when cfg_valid && cfg_ready.
- tick  out  1  registered one-cycle enable pulse to datapath.
- state  out  2  current state: 0 HALT, 1 RUN, 2 STOP, 3 STEP.
- tick_count  out  CNT_W  number of ticks issued; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=HALT, tick=0, tick_count=0.
  - Internal cnt=0, div=DEFAULT_DIV.
  - cfg_ready=1, since it is combinational from state.
- cfg_ready = (state==HALT). Handshake rules:
  - cfg_valid outside HALT stalls; the source must hold cfg_valid/cfg_div until accepted.
  - On accept: div<=cfg_div at that edge.
- Command priority when asserted together: halt > step > run. Commands not listed for a state are ignored.
- HALT:
  - tick=0; cnt held at 0.
  - cmd_run -> RUN, cnt<=0.
  - cmd_step -> STEP.
  - If cfg accept and cmd_run occur in the same cycle, the new div applies from the first RUN cycle.
- RUN:
  - Each cycle, if cnt==div: cnt<=0, tick<=1. Otherwise cnt<=cnt+1, tick<=0.
  - Result: first tick is high in RUN cycle div+2 after entry; ticks then repeat every div+1 cycles.
  - div=0 gives tick high every cycle from the 2nd RUN cycle.
  - cmd_halt -> STOP (counting continues).
- STOP:
  - Counting continues as in RUN.
  - At the edge where cnt==div: tick<=1, state<=HALT, cnt<=0. The final tick is always delivered; a halt never truncates a period.
  - cmd_run in STOP -> RUN with no counter disturbance.
  - cmd_halt in STOP is ignored.
- STEP:
  - Lasts exactly one cycle. At its exit edge: tick<=1, state<=HALT.
  - A tick pulse is therefore high in the cycle after STEP.
  - Commands in STEP are ignored.
- tick_count increments on every edge that sets tick<=1 and wraps from 2^CNT_W-1 to 0.
- tick is never high for two consecutive cycles unless div=0 in RUN.
- Counter compare is unsigned equality over DIV_W bits; cnt never exceeds div, because div only changes in HALT, where cnt=0.
- Reset mid-operation (any state, including with tick high):
  - All outputs return to reset values immediately.
  - div returns to DEFAULT_DIV.
  - No pending command or config survives reset.

Test Plan:
- Reset, then cmd_run pulse with default div=15 -> tick high in RUN cycles 17, 33, 49; tick_count=3 after third tick; each tick exactly 1 cycle wide.
- In HALT, cfg_valid with cfg_div=2 accepted (cfg_ready=1), then cmd_run -> tick every 3 cycles; cfg_valid=1 with cfg_div=7 during RUN -> cfg_ready=0, div unchanged, ticks stay 3-cycle period.
- Running with div=4, cmd_halt asserted when cnt=1 -> state=STOP for 3 cycles, exactly one more tick, then state=HALT, tick=0 thereafter; cmd_run asserted during STOP instead -> back to RUN, period unbroken.
- In HALT, cmd_step with cmd_run held high in the same cycle -> state=STEP for 1 cycle, single tick, returns to HALT; tick_count +1; run ignored.
- div=0 run -> tick continuously high from 2nd RUN cycle; CNT_W=4 override, 17 ticks -> tick_count wraps to 1.
- rst_n asserted low asynchronously mid-RUN while tick=1 -> tick, tick_count, state clear without a clock edge; div back to 15.
